// File: rtl/serial_demux_tx.sv
// ============================================================================
//  Module   : serial_demux_tx
//  Purpose  : Framed serial demultiplexer. Decodes start/address/length,
//             steers payload bits to one of NPORTS outputs and shows the
//             remaining bit count on a seven-segment digit.
//             Optional even-parity check enabled by `define PARITY_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_demux_tx #(
    parameter int NPORTS = 4,
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              SerIn,
    output logic              SerOutValid,
    output logic              Done,
    output logic              Err,
    output logic [NPORTS-1:0] P,
    output logic [LEN_W-1:0]  Rem,
    output logic [6:0]        SSD_Out
);

    localparam int c_max_field = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int c_cnt_w     = $clog2(c_max_field + 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_addr = 3'd1;
    localparam logic [2:0] c_st_len  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
`ifdef PARITY_CHECK_EN
    localparam logic [2:0] c_st_par  = 3'd4;
`endif
    localparam logic [2:0] c_st_done = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [2:0]         w_after_payload;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_rem;
    logic               r_err;
`ifdef PARITY_CHECK_EN
    logic               r_par;
`endif

    logic [ADDR_W-1:0]  w_addr_shift;
    logic [LEN_W-1:0]   w_len_shift;
    logic               w_addr_last;
    logic               w_len_last;
    logic [NPORTS-1:0]  w_port_hit;
    logic               w_addr_ok;
    logic               w_err_set;
    logic [3:0]         w_digit;

    assign w_addr_shift = (r_addr << 1) | ADDR_W'(SerIn);
    assign w_len_shift  = (r_rem << 1) | LEN_W'(SerIn);
    assign w_addr_last  = (r_cnt == c_cnt_w'(ADDR_W - 1));
    assign w_len_last   = (r_cnt == c_cnt_w'(LEN_W - 1));

`ifdef PARITY_CHECK_EN
    assign w_after_payload = c_st_par;
    assign w_err_set       = ~w_addr_ok | ((r_state == c_st_par) & (r_par ^ SerIn));
`else
    assign w_after_payload = c_st_done;
    assign w_err_set       = ~w_addr_ok;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else if (clkEn) begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (clkEn) begin
            case (r_state)
                c_st_idle: if (!SerIn) w_next_state = c_st_addr;
                c_st_addr: if (w_addr_last) w_next_state = c_st_len;
                c_st_len: begin
                    if (w_len_last) begin
                        w_next_state = (w_len_shift == '0) ? w_after_payload : c_st_data;
                    end
                end
                c_st_data: if (r_rem <= LEN_W'(1)) w_next_state = w_after_payload;
`ifdef PARITY_CHECK_EN
                c_st_par:  w_next_state = c_st_done;
`endif
                c_st_done: w_next_state = c_st_idle;
                default:   w_next_state = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        SerOutValid = 1'b0;
        Done        = 1'b0;
        case (r_state)
            c_st_data: SerOutValid = 1'b1;
            c_st_done: Done        = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address, length/remaining counter, error and parity
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_rem  <= '0;
            r_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par  <= 1'b0;
`endif
        end else if (clkEn) begin
            case (r_state)
                c_st_idle: begin
                    if (!SerIn) begin
                        r_cnt  <= '0;
                        r_addr <= '0;
                        r_rem  <= '0;
                        r_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
                        r_par  <= 1'b0;
`endif
                    end
                end
                c_st_addr: begin
                    r_addr <= w_addr_shift;
                    r_cnt  <= w_addr_last ? '0 : r_cnt + c_cnt_w'(1);
                end
                c_st_len: begin
                    r_rem <= w_len_shift;
                    r_cnt <= w_len_last ? '0 : r_cnt + c_cnt_w'(1);
                end
                c_st_data: begin
                    if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
`ifdef PARITY_CHECK_EN
                    r_par <= r_par ^ SerIn;
`endif
                end
                default: ;
            endcase
            // Error is latched on the single transition into DONE
            if ((w_next_state == c_st_done) && (r_state != c_st_done)) begin
                r_err <= r_err | w_err_set;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port steering: out-of-range addresses hit no port, so P stays 0
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        assign w_port_hit[i] = (r_addr == ADDR_W'(i));
        assign P[i]          = SerOutValid & w_port_hit[i] & SerIn;
    end

    assign w_addr_ok = |w_port_hit;
    assign Err       = r_err;
    assign Rem       = r_rem;

    if (LEN_W >= 4) begin : g_digit_full
        assign w_digit = r_rem[3:0];
    end else begin : g_digit_pad
        assign w_digit = {{(4 - LEN_W){1'b0}}, r_rem};
    end

    // Active-low segments, bit order gfedcba
    always_comb begin
        SSD_Out = 7'b1111111;
        case (w_digit)
            4'h0: SSD_Out = 7'b1000000;
            4'h1: SSD_Out = 7'b1111001;
            4'h2: SSD_Out = 7'b0100100;
            4'h3: SSD_Out = 7'b0110000;
            4'h4: SSD_Out = 7'b0011001;
            4'h5: SSD_Out = 7'b0010010;
            4'h6: SSD_Out = 7'b0000010;
            4'h7: SSD_Out = 7'b1111000;
            4'h8: SSD_Out = 7'b0000000;
            4'h9: SSD_Out = 7'b0010000;
            4'hA: SSD_Out = 7'b0001000;
            4'hB: SSD_Out = 7'b0000011;
            4'hC: SSD_Out = 7'b1000110;
            4'hD: SSD_Out = 7'b0100001;
            4'hE: SSD_Out = 7'b0000110;
            4'hF: SSD_Out = 7'b0001110;
            default: SSD_Out = 7'b1111111;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_demux_tx.sv
// ============================================================================
//  Module   : tb_serial_demux_tx
//  Purpose  : Directed self-checking bench for serial_demux_tx (4-port and
//             3-port instances sharing one serial stream).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_demux_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ser = 1'b1;
    logic       sel3 = 1'b0;

    logic       v4, d4, e4, v3, d3, e3;
    logic [3:0] p4;
    logic [2:0] p3;
    logic [3:0] rem4, rem3;
    logic [6:0] ssd4, ssd3;

    logic       w_valid, w_done, w_err;
    logic [3:0] w_p, w_rem;
    logic [6:0] w_ssd;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    serial_demux_tx #(.NPORTS(4), .ADDR_W(2), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .clkEn(en), .SerIn(ser),
        .SerOutValid(v4), .Done(d4), .Err(e4), .P(p4), .Rem(rem4), .SSD_Out(ssd4)
    );

    serial_demux_tx #(.NPORTS(3), .ADDR_W(2), .LEN_W(4)) dut3 (
        .clk(clk), .rst(rst), .clkEn(en), .SerIn(ser),
        .SerOutValid(v3), .Done(d3), .Err(e3), .P(p3), .Rem(rem3), .SSD_Out(ssd3)
    );

    assign w_valid = sel3 ? v3 : v4;
    assign w_done  = sel3 ? d3 : d4;
    assign w_err   = sel3 ? e3 : e4;
    assign w_p     = sel3 ? {1'b0, p3} : p4;
    assign w_rem   = sel3 ? rem3 : rem4;
    assign w_ssd   = sel3 ? ssd3 : ssd4;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One enabled step, optionally preceded by `gap` frozen clocks
    task automatic step(input logic b, input int gap, input logic ev, input logic ed,
                        input logic ee, input logic [3:0] ep, input logic [3:0] er);
        for (int g = 0; g < gap; g++) begin
            en = 1'b0; ser = ~b;
            @(posedge clk); #1;
            check("hold_valid", w_valid, ev);
            check("hold_done", w_done, ed);
            check("hold_rem", w_rem, er);
        end
        en = 1'b1; ser = b; #1;
        check("valid", w_valid, ev);
        check("done", w_done, ed);
        check("err", w_err, ee);
        check("p", w_p, ep);
        check("rem", w_rem, er);
        check("ssd", w_ssd, hex7(er));
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] a, input int len, input logic [15:0] pay,
                             input logic pb, input int gap, input logic on3,
                             input logic prev_err, input logic exp_err);
        logic [3:0] lb;
        logic [3:0] r;
        logic [3:0] ep;
        int         np;
        logic       b;
        sel3 = on3;
        np   = on3 ? 3 : 4;
        lb   = len[3:0];
        r    = 4'd0;
        step(1'b0, gap, 0, 0, prev_err, 4'd0, 4'd0);
        step(a[1], gap, 0, 0, 0, 4'd0, 4'd0);
        step(a[0], gap, 0, 0, 0, 4'd0, 4'd0);
        for (int i = 3; i >= 0; i--) begin
            step(lb[i], gap, 0, 0, 0, 4'd0, r);
            r = {r[2:0], lb[i]};
        end
        for (int k = 0; k < len; k++) begin
            b  = pay[len - 1 - k];
            ep = (int'(a) < np) ? (4'(b) << a) : 4'd0;
            step(b, gap, 1, 0, 0, ep, 4'(len - k));
        end
`ifdef PARITY_CHECK_EN
        step(pb, gap, 0, 0, 0, 4'd0, 4'd0);
`else
        r = {3'd0, pb};
`endif
        // A zero during DONE must not start a new frame
        step(1'b0, gap, 0, 1, exp_err, 4'd0, 4'd0);
    endtask

    task automatic idle(input int n, input logic ee);
        for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, ee, 4'd0, 4'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, w_valid, 0);
        check({tag, "_done"}, w_done, 0);
        check({tag, "_err"}, w_err, 0);
        check({tag, "_p"}, w_p, 0);
        check({tag, "_rem"}, w_rem, 0);
        check({tag, "_ssd"}, w_ssd, 7'b1000000);
    endtask

    initial begin
        // Reset wins over clkEn with a start bit present
        rst = 1'b1; en = 1'b1; ser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel3 = 1'b0; check_reset("rst4");
        sel3 = 1'b1; check_reset("rst3");
        sel3 = 1'b0;
        rst = 1'b0; en = 1'b0; ser = 1'b1;
        idle(2, 0);

        // Default frame 0/10/0011/101, then freeze-gapped copy
        run_frame(2'b10, 3, 16'b101, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(6, 0);
        run_frame(2'b10, 3, 16'b101, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        idle(6, 0);

        // Zero-length payload
        run_frame(2'b01, 0, 16'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(6, 0);

        // Out-of-range address on 3-port instance, then error cleared by next frame
        run_frame(2'b11, 2, 16'b11, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        idle(6, 1);
        run_frame(2'b00, 1, 16'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        idle(3, 0);

        // Reset during the second payload bit
        sel3 = 1'b0;
        step(1'b0, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b1, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b0, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b0, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b0, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b1, 0, 0, 0, 0, 4'd0, 4'd0);
        step(1'b1, 0, 0, 0, 0, 4'd0, 4'd1);
        step(1'b1, 0, 1, 0, 0, 4'b0100, 4'd3);
        en = 1'b1; ser = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        check_reset("midrst");
        idle(5, 0);
        run_frame(2'b10, 3, 16'b101, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(3, 0);

`ifdef PARITY_CHECK_EN
        // Odd total parity must flag an error
        run_frame(2'b10, 3, 16'b101, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(3, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
